// File: rtl/trng_health_mon.sv
// Online health tests (repetition count + adaptive proportion) for a raw
// entropy byte stream, with start-up gating, sticky alarm and a one-entry output.
module trng_health_mon #(
   parameter int WIDTH           = 8,
   parameter int RCT_CUTOFF      = 4,
   parameter int APT_WINDOW      = 512,
   parameter int APT_CUTOFF      = 13,
   parameter int STARTUP_SAMPLES = 1024
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [WIDTH-1:0] i_src_dat,
   input  logic             i_src_valid,
   output logic             o_src_read,
   output logic [WIDTH-1:0] o_dat,
   output logic             o_valid,
   input  logic             i_read,
   input  logic             i_clear_alarm,
   output logic             o_alarm,
   output logic             o_rct_fail,
   output logic             o_apt_fail,
   output logic [1:0]       o_state,
   output logic [7:0]       o_alarm_cnt
);

   localparam int RCW = $clog2(RCT_CUTOFF + 1);
   localparam int AIW = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;
   localparam int ACW = $clog2(APT_CUTOFF + 1);
   localparam int SCW = $clog2(STARTUP_SAMPLES + 1);

   typedef enum logic [1:0] {
      ST_STARTUP = 2'd0,
      ST_RUN     = 2'd1,
      ST_ALARM   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dat_q, dat_d;
   logic             valid_q, valid_d;
   logic             rct_have_q, rct_have_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [RCW-1:0]   rct_cnt_q, rct_cnt_d;
   logic [AIW-1:0]   apt_idx_q, apt_idx_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [ACW-1:0]   apt_cnt_q, apt_cnt_d;
   logic [SCW-1:0]   start_cnt_q, start_cnt_d;
   logic             rct_flag_q, rct_flag_d;
   logic             apt_flag_q, apt_flag_d;
   logic [7:0]       alarm_cnt_q, alarm_cnt_d;

   logic             accept;
   logic [RCW-1:0]   rct_cnt_nx;
   logic [ACW-1:0]   apt_cnt_nx;
   logic             rct_fail, apt_fail, fail;

   always_comb begin
      accept = i_src_valid && (state_q != ST_ALARM) && (!valid_q || i_read);

      // History is empty after reset/clear, so the first sample restarts the run
      if (rct_have_q && (i_src_dat == last_q)) begin
         rct_cnt_nx = (rct_cnt_q == RCW'(RCT_CUTOFF)) ? rct_cnt_q
                                                      : rct_cnt_q + RCW'(1);
      end else begin
         rct_cnt_nx = RCW'(1);
      end

      if (apt_idx_q == '0) begin
         apt_cnt_nx = ACW'(1);
      end else if (i_src_dat == ref_q) begin
         apt_cnt_nx = apt_cnt_q + ACW'(1);
      end else begin
         apt_cnt_nx = apt_cnt_q;
      end

      rct_fail = accept && (rct_cnt_nx == RCW'(RCT_CUTOFF));
      apt_fail = accept && (apt_cnt_nx == ACW'(APT_CUTOFF));
      fail     = rct_fail || apt_fail;
   end

   always_comb begin
      state_d     = state_q;
      dat_d       = dat_q;
      valid_d     = valid_q;
      rct_have_d  = rct_have_q;
      last_d      = last_q;
      rct_cnt_d   = rct_cnt_q;
      apt_idx_d   = apt_idx_q;
      ref_d       = ref_q;
      apt_cnt_d   = apt_cnt_q;
      start_cnt_d = start_cnt_q;
      rct_flag_d  = rct_flag_q;
      apt_flag_d  = apt_flag_q;
      alarm_cnt_d = alarm_cnt_q;

      if (valid_q && i_read) valid_d = 1'b0;

      if (accept) begin
         rct_have_d = 1'b1;
         last_d     = i_src_dat;
         rct_cnt_d  = rct_cnt_nx;
         apt_cnt_d  = apt_cnt_nx;
         if (apt_idx_q == '0) ref_d = i_src_dat;
         apt_idx_d  = (apt_idx_q == AIW'(APT_WINDOW - 1)) ? '0
                                                          : apt_idx_q + AIW'(1);
      end

      unique case (state_q)
         ST_STARTUP: begin
            if (accept && !fail) begin
               start_cnt_d = start_cnt_q + SCW'(1);
               if (start_cnt_d == SCW'(STARTUP_SAMPLES)) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept && !fail) begin
               dat_d   = i_src_dat;
               valid_d = 1'b1;
            end
         end
         ST_ALARM: begin
            valid_d = 1'b0;
            if (i_clear_alarm) begin
               state_d     = ST_STARTUP;
               start_cnt_d = '0;
               rct_have_d  = 1'b0;
               rct_cnt_d   = '0;
               apt_idx_d   = '0;
               apt_cnt_d   = '0;
               rct_flag_d  = 1'b0;
               apt_flag_d  = 1'b0;
            end
         end
         default: state_d = ST_STARTUP;
      endcase

      // A failing sample is dropped and the pipeline is flushed
      if (fail) begin
         state_d    = ST_ALARM;
         valid_d    = 1'b0;
         rct_flag_d = rct_flag_q || rct_fail;
         apt_flag_d = apt_flag_q || apt_fail;
         if (alarm_cnt_q != 8'hFF) alarm_cnt_d = alarm_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= ST_STARTUP;
         dat_q       <= '0;
         valid_q     <= 1'b0;
         rct_have_q  <= 1'b0;
         last_q      <= '0;
         rct_cnt_q   <= '0;
         apt_idx_q   <= '0;
         ref_q       <= '0;
         apt_cnt_q   <= '0;
         start_cnt_q <= '0;
         rct_flag_q  <= 1'b0;
         apt_flag_q  <= 1'b0;
         alarm_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         dat_q       <= dat_d;
         valid_q     <= valid_d;
         rct_have_q  <= rct_have_d;
         last_q      <= last_d;
         rct_cnt_q   <= rct_cnt_d;
         apt_idx_q   <= apt_idx_d;
         ref_q       <= ref_d;
         apt_cnt_q   <= apt_cnt_d;
         start_cnt_q <= start_cnt_d;
         rct_flag_q  <= rct_flag_d;
         apt_flag_q  <= apt_flag_d;
         alarm_cnt_q <= alarm_cnt_d;
      end
   end

   assign o_src_read  = accept;
   assign o_dat       = dat_q;
   assign o_valid     = valid_q;
   assign o_alarm     = (state_q == ST_ALARM);
   assign o_rct_fail  = rct_flag_q;
   assign o_apt_fail  = apt_flag_q;
   assign o_state     = state_q;
   assign o_alarm_cnt = alarm_cnt_q;

endmodule

// File: tb/tb_trng_health_mon.sv
// Directed scenario bench for trng_health_mon: start-up, RCT, APT,
// backpressure, alarm clear and asynchronous reset.
module tb_trng_health_mon;

   logic       i_clk = 1'b0;
   logic       i_reset_n;
   logic [7:0] i_src_dat;
   logic       i_src_valid;
   logic       o_src_read;
   logic [7:0] o_dat;
   logic       o_valid;
   logic       i_read;
   logic       i_clear_alarm;
   logic       o_alarm;
   logic       o_rct_fail;
   logic       o_apt_fail;
   logic [1:0] o_state;
   logic [7:0] o_alarm_cnt;

   int tests = 0;
   int fails = 0;

   trng_health_mon dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_src_dat    (i_src_dat),
      .i_src_valid  (i_src_valid),
      .o_src_read   (o_src_read),
      .o_dat        (o_dat),
      .o_valid      (o_valid),
      .i_read       (i_read),
      .i_clear_alarm(i_clear_alarm),
      .o_alarm      (o_alarm),
      .o_rct_fail   (o_rct_fail),
      .o_apt_fail   (o_apt_fail),
      .o_state      (o_state),
      .o_alarm_cnt  (o_alarm_cnt)
   );

   always #5 i_clk = ~i_clk;

   // Present one sample and step one clock; outputs are looked at 1ns after the edge.
   task automatic feed(input logic [7:0] d);
      i_src_dat   = d;
      i_src_valid = 1'b1;
      @(posedge i_clk);
      #1;
   endtask

   // Feed n samples 0,1,2,... (mod 256); count cycles with o_valid high or no accept.
   task automatic run_startup(input int n, output int vbad, output int rbad);
      vbad = 0;
      rbad = 0;
      for (int i = 0; i < n; i++) begin
         i_src_dat   = 8'(i);
         i_src_valid = 1'b1;
         #1;
         if (o_src_read !== 1'b1) rbad++;
         @(posedge i_clk);
         #1;
         if (o_valid !== 1'b0) vbad++;
      end
   endtask

   task automatic do_clear();
      i_src_valid   = 1'b0;
      i_clear_alarm = 1'b1;
      @(posedge i_clk);
      #1;
      i_clear_alarm = 1'b0;
   endtask

   task automatic test_reset();
      i_reset_n     = 1'b0;
      i_src_dat     = 8'h00;
      i_src_valid   = 1'b1;
      i_read        = 1'b1;
      i_clear_alarm = 1'b0;
      #12;
      tests++;
      if (o_state !== 2'd0 || o_valid !== 1'b0 || o_dat !== 8'h00) begin
         fails++;
         $display("FAIL reset_out: state=%0d valid=%b dat=%h req 0/0/00", o_state, o_valid, o_dat);
      end
      tests++;
      if (o_alarm !== 1'b0 || o_rct_fail !== 1'b0 || o_apt_fail !== 1'b0 || o_alarm_cnt !== 8'd0) begin
         fails++;
         $display("FAIL reset_flags: alarm=%b rct=%b apt=%b cnt=%0d req 0/0/0/0",
                  o_alarm, o_rct_fail, o_apt_fail, o_alarm_cnt);
      end
      tests++;
      if (o_src_read !== 1'b1) begin
         fails++;
         $display("FAIL reset_src_read: got %b req 1", o_src_read);
      end
      @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
   endtask

   task automatic test_startup();
      int vb, rb;
      run_startup(1023, vb, rb);
      tests++;
      if (vb != 0 || rb != 0) begin
         fails++;
         $display("FAIL startup_gate: valid_cycles=%0d noread_cycles=%0d req 0/0", vb, rb);
      end
      tests++;
      if (o_state !== 2'd0) begin
         fails++;
         $display("FAIL startup_1023: state=%0d req 0", o_state);
      end
      feed(8'hFF);
      tests++;
      if (o_state !== 2'd1 || o_valid !== 1'b0) begin
         fails++;
         $display("FAIL startup_1024: state=%0d valid=%b req 1/0", o_state, o_valid);
      end
      feed(8'h00);
      tests++;
      if (o_valid !== 1'b1 || o_dat !== 8'h00) begin
         fails++;
         $display("FAIL startup_first_fwd: valid=%b dat=%h req 1/00", o_valid, o_dat);
      end
   endtask

   task automatic test_rct();
      for (int k = 0; k < 3; k++) begin
         feed(8'h5A);
         tests++;
         if (o_valid !== 1'b1 || o_dat !== 8'h5A || o_state !== 2'd1) begin
            fails++;
            $display("FAIL rct_fwd%0d: valid=%b dat=%h state=%0d req 1/5a/1", k, o_valid, o_dat, o_state);
         end
      end
      feed(8'h5A);
      tests++;
      if (o_alarm !== 1'b1 || o_state !== 2'd2 || o_valid !== 1'b0) begin
         fails++;
         $display("FAIL rct_alarm: alarm=%b state=%0d valid=%b req 1/2/0", o_alarm, o_state, o_valid);
      end
      tests++;
      if (o_rct_fail !== 1'b1 || o_apt_fail !== 1'b0 || o_alarm_cnt !== 8'd1) begin
         fails++;
         $display("FAIL rct_flags: rct=%b apt=%b cnt=%0d req 1/0/1", o_rct_fail, o_apt_fail, o_alarm_cnt);
      end
      tests++;
      if (o_src_read !== 1'b0) begin
         fails++;
         $display("FAIL rct_src_read: got %b req 0", o_src_read);
      end
      @(posedge i_clk);
      #1;
      tests++;
      if (o_state !== 2'd2 || o_alarm_cnt !== 8'd1) begin
         fails++;
         $display("FAIL rct_hold: state=%0d cnt=%0d req 2/1", o_state, o_alarm_cnt);
      end
   endtask

   task automatic test_clear();
      int vb, rb;
      do_clear();
      tests++;
      if (o_state !== 2'd0 || o_alarm !== 1'b0 || o_rct_fail !== 1'b0 || o_apt_fail !== 1'b0) begin
         fails++;
         $display("FAIL clear_state: state=%0d alarm=%b rct=%b apt=%b req 0/0/0/0",
                  o_state, o_alarm, o_rct_fail, o_apt_fail);
      end
      tests++;
      if (o_alarm_cnt !== 8'd1) begin
         fails++;
         $display("FAIL clear_cnt: got %0d req 1", o_alarm_cnt);
      end
      run_startup(1023, vb, rb);
      tests++;
      if (vb != 0 || rb != 0 || o_state !== 2'd0) begin
         fails++;
         $display("FAIL clear_restart: valid_cycles=%0d noread=%0d state=%0d req 0/0/0", vb, rb, o_state);
      end
      feed(8'hFF);
      tests++;
      if (o_state !== 2'd1 || o_valid !== 1'b0) begin
         fails++;
         $display("FAIL clear_run: state=%0d valid=%b req 1/0", o_state, o_valid);
      end
      do_clear();
      tests++;
      if (o_state !== 2'd1) begin
         fails++;
         $display("FAIL clear_ignored: state=%0d req 1", o_state);
      end
   endtask

   task automatic test_apt_fail();
      feed(8'h11);
      tests++;
      if (o_valid !== 1'b1 || o_dat !== 8'h11) begin
         fails++;
         $display("FAIL apt_ref_fwd: valid=%b dat=%h req 1/11", o_valid, o_dat);
      end
      for (int k = 0; k < 12; k++) begin
         feed(8'h20 + 8'(k));
         feed(8'h11);
         tests++;
         if (o_state !== ((k == 11) ? 2'd2 : 2'd1)) begin
            fails++;
            $display("FAIL apt_match%0d: state=%0d req %0d", k + 2, o_state, (k == 11) ? 2 : 1);
         end
      end
      tests++;
      if (o_apt_fail !== 1'b1 || o_rct_fail !== 1'b0 || o_alarm_cnt !== 8'd2 || o_valid !== 1'b0) begin
         fails++;
         $display("FAIL apt_flags: apt=%b rct=%b cnt=%0d valid=%b req 1/0/2/0",
                  o_apt_fail, o_rct_fail, o_alarm_cnt, o_valid);
      end
   endtask

   task automatic test_apt_window();
      int vb, rb;
      do_clear();
      run_startup(1024, vb, rb);
      feed(8'h11);
      for (int k = 0; k < 11; k++) begin
         feed(8'h40 + 8'(k));
         feed(8'h11);
      end
      for (int k = 0; k < 489; k++) feed(8'h80 + 8'(k % 64));
      tests++;
      if (o_state !== 2'd1 || o_valid !== 1'b1 || o_dat !== 8'hA8) begin
         fails++;
         $display("FAIL apt_12_no_alarm: state=%0d valid=%b dat=%h req 1/1/a8", o_state, o_valid, o_dat);
      end
      feed(8'h33);
      for (int k = 0; k < 12; k++) begin
         feed(8'h40 + 8'(k));
         if (k == 11) begin
            tests++;
            if (o_state !== 2'd1) begin
               fails++;
               $display("FAIL apt_newref_pre: state=%0d req 1", o_state);
            end
         end
         feed(8'h33);
      end
      tests++;
      if (o_state !== 2'd2 || o_apt_fail !== 1'b1 || o_rct_fail !== 1'b0 || o_alarm_cnt !== 8'd3) begin
         fails++;
         $display("FAIL apt_newref: state=%0d apt=%b rct=%b cnt=%0d req 2/1/0/3",
                  o_state, o_apt_fail, o_rct_fail, o_alarm_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int vb, rb;
      do_clear();
      run_startup(1024, vb, rb);
      feed(8'h01);
      tests++;
      if (o_valid !== 1'b1 || o_dat !== 8'h01) begin
         fails++;
         $display("FAIL bp_first: valid=%b dat=%h req 1/01", o_valid, o_dat);
      end
      i_read    = 1'b0;
      i_src_dat = 8'h02;
      #1;
      tests++;
      if (o_src_read !== 1'b0) begin
         fails++;
         $display("FAIL bp_src_read: got %b req 0", o_src_read);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge i_clk);
         #1;
         tests++;
         if (o_valid !== 1'b1 || o_dat !== 8'h01 || o_src_read !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d: valid=%b dat=%h src_read=%b req 1/01/0", k, o_valid, o_dat, o_src_read);
         end
      end
      i_read = 1'b1;
      #1;
      tests++;
      if (o_src_read !== 1'b1) begin
         fails++;
         $display("FAIL bp_release: src_read=%b req 1", o_src_read);
      end
      @(posedge i_clk);
      #1;
      tests++;
      if (o_valid !== 1'b1 || o_dat !== 8'h02) begin
         fails++;
         $display("FAIL bp_replace: valid=%b dat=%h req 1/02", o_valid, o_dat);
      end
      feed(8'h03);
      tests++;
      if (o_valid !== 1'b1 || o_dat !== 8'h03) begin
         fails++;
         $display("FAIL bp_stream: valid=%b dat=%h req 1/03", o_valid, o_dat);
      end
   endtask

   task automatic test_reset_mid();
      i_reset_n = 1'b0;
      #1;
      tests++;
      if (o_valid !== 1'b0 || o_state !== 2'd0 || o_alarm_cnt !== 8'd0 || o_dat !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid: valid=%b state=%0d cnt=%0d dat=%h req 0/0/0/00",
                  o_valid, o_state, o_alarm_cnt, o_dat);
      end
      @(posedge i_clk);
      #1;
      i_reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_startup();
      test_rct();
      test_clear();
      test_apt_fail();
      test_apt_window();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
